sram_req_arbiter: RTL
=====================

// Module: sram_req_arbiter
// PURPOSE
//   Shares one SRAM-like slave port (the AXI bridge input) between two SRAM-like masters:
//   m0 = instruction fetch, m1 = data access.
//   Grants one request at a time, with data priority and an anti-starvation age limit.
//   Tracks in-flight ownership in an in-order FIFO so each s_data_ok goes back to the issuing master.
//   Sits between the CPU core and the AXI bridge, and allows multiple outstanding transactions.
// PARAMETERS
//   OUTSTANDING  2  max accepted-but-unanswered transactions (power of 2, >=1)
//   AGE_LIMIT    4  consecutive contested m1 grants before m0 is forced to win
// PORTS
//   aclk                  in   1   clock, all logic on rising edge
//   areset                in   1   synchronous, active-high reset
//   m{0,1}_req            in   1   master request
//   m{0,1}_wr             in   1   1=write, 0=read
//   m{0,1}_size           in   2   0=byte, 1=half, 2=word
//   m{0,1}_addr           in   32  byte address
//   m{0,1}_wstrb          in   4   byte strobes
//   m{0,1}_wdata          in   32  write data
//   m{0,1}_addr_ok        out  1   request accepted this cycle
//   m{0,1}_data_ok        out  1   response for this master this cycle
//   m{0,1}_rdata          out  32  read data (valid with data_ok)
//   s_req/wr/size/addr/wstrb/wdata  out  1/1/2/32/4/32  request forwarded from the granted master
//   s_addr_ok             in   1   slave accepted request
//   s_data_ok             in   1   slave response (strictly in order)
//   s_rdata               in   32  slave read data
//   err_unexp             out  1   sticky: s_data_ok seen while the ownership FIFO was empty
// BEHAVIOUR
// - Reset values: state=IDLE, grant=m0, age=0, FIFO count=0, err_unexp=0; s_req and all *_ok outputs = 0.
// - FSM IDLE:
//   - Winner = m1 if only m1 requests; m0 if only m0 requests.
//   - If both request: m1, unless age==AGE_LIMIT, in which case m0.
//   - If any request && count<OUTSTANDING: register grant, go to LOCK.
//   - No request, or FIFO full: stay in IDLE; s_req=0.
// - FSM LOCK:
//   - s_req = m[grant]_req; s_wr/size/addr/wstrb/wdata = m[grant] fields (combinational mux on the registered grant).
//   - s_addr_ok && s_req: m[grant]_addr_ok=1 same cycle; push grant into FIFO; go to IDLE.
//   - m[grant]_req==0: abandon with no push; go to IDLE.
//   - m[!grant]_addr_ok is always 0.
// - Latency: request sampled at cycle t gives s_req at t+1 at the earliest. The back-to-back issue rate is one accept every 2 cycles.
// - Age counter: updated only on contested grants (both requesting in IDLE).
//   - m1 wins: age = age+1, saturating at AGE_LIMIT.
//   - m0 wins contested: age = 0.
//   - Uncontested grants leave age unchanged.
// - Response routing:
//   - On s_data_ok with count>0: m[head]_data_ok=1 same cycle; pop.
//   - m0_rdata = m1_rdata = s_rdata (pass-through, no register).
// - FIFO count arithmetic:
//   - Push only: +1. Pop only: -1. Push and pop same cycle: unchanged. Pointers wrap modulo OUTSTANDING.
//   - Full (count==OUTSTANDING) blocks IDLE->LOCK. A pop at full allows LOCK on the next cycle.
// - s_data_ok with count==0: no data_ok to either master, count stays 0, err_unexp<=1 until areset.
// - areset mid-transaction: everything returns to reset values next edge.
//   - In-flight responses are forgotten; a later stray s_data_ok sets err_unexp.
// - The grant never changes while in LOCK, so slave-facing fields are stable until s_addr_ok or abandon.
// TESTING
// - m0 read alone, addr=0x1C000000:
//   - m0_req@t0 -> s_req=1, s_addr=0x1C000000@t1.
//   - s_addr_ok@t1 -> m0_addr_ok@t1.
//   - s_data_ok, s_rdata=0x12345678 @t4 -> m0_data_ok=1, m0_rdata=0x12345678 @t4; m1_data_ok=0.
// - Both masters requesting continuously, AGE_LIMIT=4, slave accepting immediately:
//   - Grant order m1,m1,m1,m1,m0,m1,m1,m1,m1,m0.
// - OUTSTANDING=2:
//   - Two accepts with no s_data_ok -> s_req stays 0 with m0_req held.
//   - s_data_ok@t -> s_req=1 @t+2.
// - Interleaved ownership: m0 read accepted, then m1 write accepted.
//   - 1st s_data_ok -> m0_data_ok only; 2nd s_data_ok -> m1_data_ok only.
// - count=1 with s_data_ok and s_addr_ok in the same cycle -> count stays 1; next response routes to the newer owner.
// - Stray s_data_ok at count=0 -> err_unexp=1 and stays 1.
//   - areset during LOCK -> next cycle s_req=0, count=0, err_unexp=0.

Source files
------------

// File: rtl/sram_req_arbiter.sv
// Two-master to one-slave SRAM-like request arbiter. Data (m1) has priority, instruction (m0) is
// protected by an age limit, and an in-order ownership FIFO steers each response back to its issuer.
module sram_req_arbiter #(
    parameter int OUTSTANDING = 2,
    parameter int AGE_LIMIT   = 4
) (
    input  logic        aclk,
    input  logic        areset,

    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_wdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_wdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic [31:0] m1_rdata,

    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata,

    output logic        err_unexp
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam int AGE_W = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t             state_reg;
    logic               grant_reg;
    logic [AGE_W-1:0]   age_reg;
    logic [AGE_W-1:0]   age_next;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic               err_reg;
    logic               own_mem [OUTSTANDING];

    // Master-side signals gathered into vectors indexed by master number
    logic [1:0]         m_req;
    logic [1:0]         m_wr;
    logic [1:0][1:0]    m_size;
    logic [1:0][31:0]   m_addr;
    logic [1:0][3:0]    m_wstrb;
    logic [1:0][31:0]   m_wdata;
    logic [1:0]         addr_ok_vec;
    logic [1:0]         data_ok_vec;

    assign m_req   = {m1_req, m0_req};
    assign m_wr    = {m1_wr, m0_wr};
    assign m_size  = {m1_size, m0_size};
    assign m_addr  = {m1_addr, m0_addr};
    assign m_wstrb = {m1_wstrb, m0_wstrb};
    assign m_wdata = {m1_wdata, m0_wdata};

    logic in_lock;
    logic accept;
    logic release_lock;
    logic rsp_valid;
    logic head_owner;
    logic contested;
    logic any_req;
    logic fifo_room;
    logic can_issue;
    logic winner;

    assign in_lock      = (state_reg == LOCK);
    assign s_req        = in_lock & m_req[grant_reg];
    assign s_wr         = m_wr[grant_reg];
    assign s_size       = m_size[grant_reg];
    assign s_addr       = m_addr[grant_reg];
    assign s_wstrb      = m_wstrb[grant_reg];
    assign s_wdata      = m_wdata[grant_reg];

    assign accept       = s_req & s_addr_ok;
    // A locked master that drops its request abandons the slot without a push
    assign release_lock = in_lock & (accept | ~m_req[grant_reg]);
    assign rsp_valid    = s_data_ok & (count_reg != '0);
    assign head_owner   = own_mem[rd_ptr_reg];

    assign contested    = &m_req;
    assign any_req      = |m_req;
    assign fifo_room    = (count_reg < CNT_W'(OUTSTANDING));
    assign can_issue    = (state_reg == IDLE) & any_req & fifo_room;
    assign winner       = contested ? (age_reg != AGE_W'(AGE_LIMIT)) : m_req[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign addr_ok_vec[gi] = accept & (grant_reg == 1'(gi));
            assign data_ok_vec[gi] = rsp_valid & (head_owner == 1'(gi));
        end
    endgenerate

    assign m0_addr_ok = addr_ok_vec[0];
    assign m1_addr_ok = addr_ok_vec[1];
    assign m0_data_ok = data_ok_vec[0];
    assign m1_data_ok = data_ok_vec[1];
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;
    assign err_unexp  = err_reg;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        count_next = count_reg;
        case ({accept, rsp_valid})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Only contested grants move the age: m1 wins climb towards the limit, an m0 win clears it
    always_comb begin
        age_next = age_reg;
        if (can_issue && contested) begin
            if (winner)
                age_next = (age_reg == AGE_W'(AGE_LIMIT)) ? age_reg : age_reg + AGE_W'(1);
            else
                age_next = '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg  <= IDLE;
            grant_reg  <= 1'b0;
            age_reg    <= '0;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (can_issue) begin
                        grant_reg <= winner;
                        state_reg <= LOCK;
                    end
                end
                LOCK: begin
                    if (release_lock)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
            age_reg   <= age_next;
            count_reg <= count_next;
            if (accept)
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (rsp_valid)
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            if (s_data_ok && count_reg == '0)
                err_reg <= 1'b1;
        end
    end

    // Ownership storage needs no reset: entries are only read below the valid count
    always_ff @(posedge aclk) begin
        if (accept)
            own_mem[wr_ptr_reg] <= grant_reg;
    end

endmodule
